// File: rtl/tick_period_meter.sv
// tick_period_meter
//   Receive-side checker for a divided-clock tick stream. It counts clk cycles between
//   rising edges of tick_in and reports each measured period. It declares lock after
//   LOCK_N consecutive periods that fall within EXPECTED +/- TOL, and it flags loss of
//   tick after TIMEOUT cycles with no edge.
//
// Ports
//   clk          in   1      system clock, all logic on posedge
//   reset        in   1      synchronous, active-low reset
//   tick_in      in   1      tick/pulse stream, synchronous to clk
//   period       out  CNT_W  last measured period in clk cycles, held between updates
//   period_valid out  1      one-cycle pulse when period was updated
//   in_tol       out  1      last period was within EXPECTED +/- TOL
//   locked       out  1      LOCK_N consecutive in-tolerance periods seen
//   timeout      out  1      sticky loss-of-tick flag, cleared by the next edge

module tick_period_meter #(
    parameter int CNT_W    = 8,
    parameter int EXPECTED = 5,
    parameter int TOL      = 0,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_tol,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   EXP_C     = (CNT_W+1)'(EXPECTED);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       match_q, match_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             in_tol_q, in_tol_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             tick_rise;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   abs_diff;
    logic             cnt_in_tol;
    logic [3:0]       match_inc;

    assign tick_rise = tick_in & ~tick_q;

    // The distance from EXPECTED is taken one bit wider than the counter so that
    // neither direction of the subtraction can wrap.
    assign cnt_ext    = {1'b0, cnt_q};
    assign abs_diff   = (cnt_ext >= EXP_C) ? (cnt_ext - EXP_C) : (EXP_C - cnt_ext);
    assign cnt_in_tol = (abs_diff <= TOL_C);
    assign match_inc  = match_q + 4'd1;

    always_comb begin
        tick_d    = tick_in;
        state_d   = state_q;
        match_d   = match_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        in_tol_d  = in_tol_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        // Counter restarts at 1 on an edge so that at the next edge it holds the
        // number of cycles between the two. It saturates rather than wrapping.
        if (tick_rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == TIMEOUT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                // First edge after reset or timeout only establishes a reference.
                if (tick_rise) begin
                    state_d   = MEAS;
                    timeout_d = 1'b0;
                end
            end
            MEAS, LOCKED: begin
                // An edge takes priority over a timeout on the same cycle.
                if (tick_rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    in_tol_d = cnt_in_tol;
                    if (cnt_in_tol) begin
                        if (state_q == MEAS) begin
                            match_d = match_inc;
                            if (match_inc == LOCK_C) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        match_d  = 4'd0;
                        locked_d = 1'b0;
                        state_d  = MEAS;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = 4'd0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            match_q   <= 4'd0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            in_tol_q  <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            in_tol_q  <= in_tol_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign in_tol       = in_tol_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter
//   Self-checking bench for tick_period_meter. Instance 0 uses the default parameters,
//   instance 1 uses TOL=1. Expected period reports are queued when a tick is driven and
//   compared when period_valid pulses.

module tb_tick_period_meter;

    typedef struct packed {
        logic [7:0] period;
        logic       tol;
        logic       lock;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       tick0, tick1;
    logic [7:0] per0, per1;
    logic       val0, val1, tol0, tol1, lck0, lck1, to0, to1;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;

    int tests_run = 0;
    int tests_failed = 0;

    tick_period_meter #(.CNT_W(8), .EXPECTED(5), .TOL(0), .LOCK_N(4), .TIMEOUT(255)) dut0 (
        .clk(clk), .reset(reset), .tick_in(tick0), .period(per0), .period_valid(val0),
        .in_tol(tol0), .locked(lck0), .timeout(to0)
    );

    tick_period_meter #(.CNT_W(8), .EXPECTED(5), .TOL(1), .LOCK_N(4), .TIMEOUT(255)) dut1 (
        .clk(clk), .reset(reset), .tick_in(tick1), .period(per1), .period_valid(val1),
        .in_tol(tol1), .locked(lck1), .timeout(to1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Waits gap-1 cycles, then drives a one-cycle pulse. After a previous one-cycle
    // pulse this spaces rising edges exactly gap cycles apart.
    task automatic applyStimulus(input int dut, input int gap, input bit has_valid,
                                 input int exp_period, input bit exp_tol, input bit exp_lock);
        exp_t e;
        repeat (gap - 1) @(negedge clk);
        if (has_valid) begin
            e.period = 8'(exp_period);
            e.tol    = exp_tol;
            e.lock   = exp_lock;
            if (dut == 0) sb0.push_back(e);
            else          sb1.push_back(e);
        end
        if (dut == 0) tick0 = 1'b1;
        else          tick1 = 1'b1;
        @(negedge clk);
        if (dut == 0) tick0 = 1'b0;
        else          tick1 = 1'b0;
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_period"},  int'(per0), 0);
        checkOutput({tag, "_valid"},   int'(val0), 0);
        checkOutput({tag, "_in_tol"},  int'(tol0), 0);
        checkOutput({tag, "_locked"},  int'(lck0), 0);
        checkOutput({tag, "_timeout"}, int'(to0),  0);
    endtask

    // Scoreboard: every period_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (val0) begin
            if (sb0.size() == 0) begin
                checkOutput("spurious_valid0", int'(val0), 0);
            end else begin
                e0 = sb0.pop_front();
                checkOutput("period0", int'(per0), int'(e0.period));
                checkOutput("in_tol0", int'(tol0), int'(e0.tol));
                checkOutput("locked0", int'(lck0), int'(e0.lock));
            end
        end
        if (val1) begin
            if (sb1.size() == 0) begin
                checkOutput("spurious_valid1", int'(val1), 0);
            end else begin
                e1 = sb1.pop_front();
                checkOutput("period1", int'(per1), int'(e1.period));
                checkOutput("in_tol1", int'(tol1), int'(e1.tol));
                checkOutput("locked1", int'(lck1), int'(e1.lock));
            end
        end
    end

    initial begin
        #200000;
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        tick0 = 1'b0;
        tick1 = 1'b0;
        repeat (3) @(negedge clk);
        checkCleared("reset");
        checkOutput("reset_locked1",  int'(lck1), 0);
        checkOutput("reset_timeout1", int'(to1),  0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // T1: arm, then steady 5-cycle periods; lock on the 4th report
        applyStimulus(0, 3, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 5, 1'b1, 5, 1'b1, i == 4);
        applyStimulus(0, 5, 1'b1, 5, 1'b1, 1'b1);

        // T2: one long period breaks lock, four good periods restore it
        applyStimulus(0, 6, 1'b1, 6, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 5, 1'b1, 5, 1'b1, i == 4);
        checkOutput("t2_relocked", int'(lck0), 1);

        // T3: ticks stop; timeout lands exactly 255 cycles after the last edge
        repeat (254) @(negedge clk);
        checkOutput("t3_timeout_early", int'(to0),  0);
        checkOutput("t3_locked_early",  int'(lck0), 1);
        @(negedge clk);
        checkOutput("t3_timeout_set", int'(to0),  1);
        checkOutput("t3_locked_drop", int'(lck0), 0);
        repeat (10) @(negedge clk);
        checkOutput("t3_timeout_sticky", int'(to0), 1);
        applyStimulus(0, 3, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("t3_timeout_clear", int'(to0), 0);
        applyStimulus(0, 5, 1'b1, 5, 1'b1, 1'b0);

        // T4: long high levels count as a single edge each
        repeat (3) @(negedge clk);
        e0.period = 8'd4; e0.tol = 1'b0; e0.lock = 1'b0;
        sb0.push_back(e0);
        tick0 = 1'b1;
        repeat (20) @(negedge clk);
        tick0 = 1'b0;
        repeat (5) @(negedge clk);
        e0.period = 8'd25; e0.tol = 1'b0; e0.lock = 1'b0;
        sb0.push_back(e0);
        tick0 = 1'b1;
        repeat (3) @(negedge clk);
        tick0 = 1'b0;
        applyStimulus(0, 3, 1'b1, 5, 1'b1, 1'b0);

        // T5: reset pulse while the counter is at 3
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkCleared("t5");
        applyStimulus(0, 3, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("t5_arm_period", int'(per0), 0);
        applyStimulus(0, 5, 1'b1, 5, 1'b1, 1'b0);

        // T6: TOL=1 instance, jittery periods still lock, 7 breaks it
        applyStimulus(1, 3, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1, 4, 1'b1, 4, 1'b1, 1'b0);
        applyStimulus(1, 6, 1'b1, 6, 1'b1, 1'b0);
        applyStimulus(1, 5, 1'b1, 5, 1'b1, 1'b0);
        applyStimulus(1, 4, 1'b1, 4, 1'b1, 1'b1);
        applyStimulus(1, 7, 1'b1, 7, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("sb0_drained", sb0.size(), 0);
        checkOutput("sb1_drained", sb1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
